// File: rtl/word_multiplier.sv
// Multi-cycle unsigned shift-add multiplier. It feeds a register_word through WE/out.
// Optional `WORD_MULTIPLIER_EARLY_TERM_EN: finish as soon as no multiplier bits remain.
module word_multiplier #(
  parameter int WIDTH = 20,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             WE,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] hi,
  output logic             ovf
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t             state, state_nx;
  logic [2*WIDTH-1:0] acc, mcand, sum;
  logic [WIDTH-1:0]   mult, mult_nx;
  logic [CNT_W-1:0]   count;
  logic               last, load;

  always_comb begin
    sum     = mult[0] ? acc + mcand : acc;
    mult_nx = mult >> 1;
`ifdef WORD_MULTIPLIER_EARLY_TERM_EN
    last    = (count == LAST_CNT) || (mult_nx == '0);
`else
    last    = (count == LAST_CNT);
`endif
  end

  // The exit edge of DONE also accepts start, so a held start restarts every WIDTH+1 edges.
  assign load = start && ((state == IDLE) || (state == DONE));

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (last) state_nx = DONE;
      DONE:    state_nx = start ? RUN : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);
  assign WE   = done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      acc   <= '0;
      mcand <= '0;
      mult  <= '0;
      count <= '0;
      out   <= '0;
      hi    <= '0;
      ovf   <= 1'b0;
    end else begin
      state <= state_nx;
      if (load) begin
        acc   <= '0;
        mcand <= {{WIDTH{1'b0}}, a};
        mult  <= b;
        count <= '0;
      end else if (state == RUN) begin
        acc   <= sum;
        mcand <= mcand << 1;
        mult  <= mult_nx;
        count <= count + CNT_W'(1);
        if (last) begin
          out <= sum[WIDTH-1:0];
          hi  <= sum[2*WIDTH-1:WIDTH];
          ovf <= |sum[2*WIDTH-1:WIDTH];
        end
      end
    end
  end

endmodule
